sparc_operand_dispatch: RTL and testbench
=========================================

SPARC_OPERAND_DISPATCH -- requirements
Module: sparc_operand_dispatch

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered operand entries; only 2 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  instruction/operand pair offered.
REQ-006 in_ready  output  1  dispatch can accept a pair this cycle.
REQ-007 instr  input  32  SPARC instruction word.
REQ-008 rs2_val  input  32  register-file value read for rs2.
REQ-009 out_valid  output  1  operand triple available to the source-operand handler.
REQ-010 out_ready  input  1  source-operand handler consumes the triple.
REQ-011 R  output  32  register operand.
REQ-012 Imm  output  22  immediate field.
REQ-013 IS  output  4  operand-select code.
REQ-014 illegal  output  1  entry decoded as an illegal or unimplemented format.

Function
REQ-015 Decode SHALL be: op=10/11 with i=1 -> IS_SIMM13, Imm={9'b0,instr[12:0]}, R=0.
REQ-016 Decode SHALL be: op=10/11 with i=0 -> IS_REG, R=rs2_val, Imm=0.
REQ-017 Decode SHALL be: op=00, op2=100 -> IS_IMM22_HI, Imm=instr[21:0], R=0.
REQ-018 Decode SHALL be: op=00, op2=010 or 110 -> IS_DISP22, Imm=instr[21:0], R=0.
REQ-019 Decode SHALL be: op=01 (call) -> IS_NONE, R=0, Imm=0, illegal=0.
REQ-020 Decode SHALL be: op=00 with any other op2 -> IS_NONE, R=0, Imm=0, illegal=1.
REQ-021 Decode SHALL be registered; an entry accepted in cycle N SHALL appear at the outputs no earlier than cycle N+1.
REQ-022 Entries SHALL be held in a DEPTH-entry FIFO; in_ready SHALL be (count<DEPTH) and SHALL depend only on registered state.
REQ-023 A push SHALL occur on in_valid&&in_ready; a pop SHALL occur on out_valid&&out_ready.
REQ-024 out_valid SHALL be (count!=0); outputs SHALL reflect the head entry and remain stable while out_valid&&!out_ready.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 When full, a pop SHALL NOT enable a push in the same cycle; in_ready rises in the following cycle.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 flush SHALL clear count and pointers next edge, drop any push in that cycle, and override a pop.
REQ-029 When out_valid=0, R, Imm, IS and illegal SHALL read 0, 0, IS_NONE and 0.

Reset
REQ-030 On rst_n low, count and pointers SHALL be 0, out_valid=0, in_ready=0, R=0, Imm=0, IS=IS_NONE and illegal=0, independent of clk.
REQ-031 in_ready SHALL go to 1 on the first edge after rst_n deasserts.
REQ-032 A reset mid-transfer SHALL discard all entries with no partial output.

Structure
REQ-033 The shared package sparc_operand_pkg SHALL hold the IS codes: IS_REG=4'b0000, IS_SIMM13=4'b0001, IS_IMM22_HI=4'b0010, IS_DISP22=4'b0011, IS_NONE=4'b1111.
REQ-034 The shared package sparc_operand_pkg SHALL also hold the op/op2 constants and the default DEPTH.
REQ-035 Storage SHALL be one sub-module, operand_fifo, holding the 32+22+4+1-bit entries; decode logic stays in the top module.

Verification
REQ-036 Bench SHALL cover: instr=32'h84006005, out_ready=1 -> next cycle IS=0001, Imm=22'h000005, R=0, illegal=0.
REQ-037 Bench SHALL cover: instr=32'h84004003, rs2_val=32'hE0000003 -> IS=0000, R=32'hE0000003, Imm=0.
REQ-038 Bench SHALL cover: instr=32'h03231113 (sethi) -> IS=0010, Imm=22'h231113; then instr=32'h10BFFFFE (ba) -> IS=0011, Imm=22'h3FFFFE.
REQ-039 Bench SHALL cover: instr=32'h00000000 -> IS=1111, illegal=1; instr=32'h40000010 (call) -> IS=1111, illegal=0.
REQ-040 Bench SHALL cover: three back-to-back pushes with out_ready=0 -> third push refused (in_ready=0); single pop -> in_ready=1 the cycle after; entries emerge in order.
REQ-041 Bench SHALL cover: two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0 and count=0; rst_n low mid-stall -> all outputs zero/IS_NONE immediately.

Source files
------------

// File: rtl/sparc_operand_dispatch_pkg.sv
// sparc_operand_pkg: operand-select codes, SPARC op/op2 fields and the buffered entry layout
package sparc_operand_pkg;
  typedef enum logic [3:0] {
    IS_REG      = 4'b0000,
    IS_SIMM13   = 4'b0001,
    IS_IMM22_HI = 4'b0010,
    IS_DISP22   = 4'b0011,
    IS_NONE     = 4'b1111
  } is_e;
  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_CALL   = 2'b01;
  localparam logic [1:0] OP_ARITH  = 2'b10;
  localparam logic [1:0] OP_MEM    = 2'b11;
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;
  localparam logic [2:0] OP2_FBFCC = 3'b110;
  localparam int DEPTH_DEFAULT = 2;
  typedef struct packed {
    logic [31:0] r;
    logic [21:0] imm;
    is_e         sel;
    logic        illegal;
  } entry_t;
endpackage

// File: rtl/sparc_operand_dispatch_if.sv
// sparc_operand_dispatch_if: instruction/operand input handshake and operand-triple output handshake
interface sparc_operand_dispatch_if;
  import sparc_operand_pkg::*;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R;
  logic [21:0] Imm;
  is_e         IS;
  logic        illegal;
  modport master (
    output flush, in_valid, instr, rs2_val, out_ready,
    input  in_ready, out_valid, R, Imm, IS, illegal
  );
  modport slave (
    input  flush, in_valid, instr, rs2_val, out_ready,
    output in_ready, out_valid, R, Imm, IS, illegal
  );
endinterface

// File: rtl/sparc_operand_dispatch_operand_fifo.sv
// operand_fifo: small circular buffer of decoded operand entries with flush
module operand_fifo
  import sparc_operand_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  entry_t                       din,
  output entry_t                       dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  // pointers and occupancy; flush wins over any push or pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // entry storage needs no reset because outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/sparc_operand_dispatch.sv
// sparc_operand_dispatch: decodes SPARC operand formats and buffers them for the source-operand handler
module sparc_operand_dispatch
  import sparc_operand_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sparc_operand_dispatch_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] count;
  logic          rdy_q;
  logic          push, pop;
  entry_t        dec, head;
  logic [1:0]    op;
  logic [2:0]    op2;
  assign op  = bus.instr[31:30];
  assign op2 = bus.instr[24:22];
  // keeps in_ready low until the first edge after reset releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else rdy_q <= 1'b1;
  end
  // operand-format decode of the offered instruction
  always_comb begin
    dec = '{r: '0, imm: '0, sel: IS_NONE, illegal: 1'b0};
    if (op == OP_ARITH || op == OP_MEM) begin
      if (bus.instr[13]) begin
        dec.sel = IS_SIMM13;
        dec.imm = {9'b0, bus.instr[12:0]};
      end else begin
        dec.sel = IS_REG;
        dec.r   = bus.rs2_val;
      end
    end else if (op == OP_BRANCH) begin
      if (op2 == OP2_SETHI) begin
        dec.sel = IS_IMM22_HI;
        dec.imm = bus.instr[21:0];
      end else if (op2 == OP2_BICC || op2 == OP2_FBFCC) begin
        dec.sel = IS_DISP22;
        dec.imm = bus.instr[21:0];
      end else begin
        dec.illegal = 1'b1;
      end
    end
  end
  assign bus.in_ready  = rdy_q && (count < CW'(DEPTH));
  assign bus.out_valid = count != '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (push),
    .pop   (pop),
    .din   (dec),
    .dout  (head),
    .count (count)
  );
  assign bus.R       = bus.out_valid ? head.r : '0;
  assign bus.Imm     = bus.out_valid ? head.imm : '0;
  assign bus.IS      = bus.out_valid ? head.sel : IS_NONE;
  assign bus.illegal = bus.out_valid && head.illegal;
endmodule

// File: tb/tb_sparc_operand_dispatch.sv
// tb_sparc_operand_dispatch: scoreboard bench for operand decode, buffering, flush and reset
module tb_sparc_operand_dispatch;
  import sparc_operand_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  entry_t q [$];
  sparc_operand_dispatch_if bus ();
  sparc_operand_dispatch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic entry_t model(input logic [31:0] ins, input logic [31:0] rs2);
    entry_t e;
    e = '0;
    e.sel = IS_NONE;
    case (ins[31:30])
      2'b01: ;
      2'b00:
        case (ins[24:22])
          3'b100: begin e.sel = IS_IMM22_HI; e.imm = ins[21:0]; end
          3'b010, 3'b110: begin e.sel = IS_DISP22; e.imm = ins[21:0]; end
          default: e.illegal = 1'b1;
        endcase
      default:
        if (ins[13]) begin e.sel = IS_SIMM13; e.imm = 22'(ins[12:0]); end
        else begin e.sel = IS_REG; e.r = rs2; end
    endcase
    return e;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_R"}, bus.R, 0);
    chk({tag, "_Imm"}, bus.Imm, 0);
    chk({tag, "_IS"}, bus.IS, IS_NONE);
    chk({tag, "_illegal"}, bus.illegal, 0);
  endtask
  // scoreboard: compare head against the oldest expected entry, then record new pushes
  always @(negedge clk) begin
    entry_t e;
    if (!rst_n) begin
      q.delete();
      chk("rst_in_ready", bus.in_ready, 0);
    end
    chk("sb_out_valid", bus.out_valid, q.size() != 0);
    if (!bus.out_valid) begin
      chk("sb_idle_R", bus.R, 0);
      chk("sb_idle_IS", bus.IS, IS_NONE);
      chk("sb_idle_illegal", bus.illegal, 0);
    end else if (q.size() != 0) begin
      e = q[0];
      chk("sb_R", bus.R, e.r);
      chk("sb_Imm", bus.Imm, 32'(e.imm));
      chk("sb_IS", bus.IS, 32'(e.sel));
      chk("sb_illegal", bus.illegal, e.illegal);
      if (bus.out_ready) void'(q.pop_front());
    end
    if (rst_n && bus.flush) q.delete();
    else if (rst_n && bus.in_valid && bus.in_ready) q.push_back(model(bus.instr, bus.rs2_val));
  end
  logic [31:0] d_ins [6] = '{32'h84006005, 32'h84004003, 32'h03231113, 32'h10BFFFFE, 32'h00000000, 32'h40000010};
  logic [31:0] d_rs2 [6] = '{32'h12345678, 32'hE0000003, 32'hFFFFFFFF, 32'h0, 32'hA5A5A5A5, 32'h1};
  logic [3:0]  d_is  [6] = '{4'b0001, 4'b0000, 4'b0010, 4'b0011, 4'b1111, 4'b1111};
  logic [21:0] d_imm [6] = '{22'h000005, 22'h0, 22'h231113, 22'h3FFFFE, 22'h0, 22'h0};
  logic [31:0] d_r   [6] = '{32'h0, 32'hE0000003, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        d_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  initial begin
    bus.flush = 0;
    bus.in_valid = 0;
    bus.instr = 0;
    bus.rs2_val = 0;
    bus.out_ready = 0;
    repeat (2) cyc();
    chk_idle("reset");
    chk("reset_in_ready", bus.in_ready, 0);
    rst_n = 1;
    chk("pre_edge_in_ready", bus.in_ready, 0);
    cyc();
    chk("post_edge_in_ready", bus.in_ready, 1);
    bus.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1;
      bus.instr = d_ins[i];
      bus.rs2_val = d_rs2[i];
      cyc();
      chk($sformatf("dir%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("dir%0d_IS", i), bus.IS, d_is[i]);
      chk($sformatf("dir%0d_Imm", i), bus.Imm, d_imm[i]);
      chk($sformatf("dir%0d_R", i), bus.R, d_r[i]);
      chk($sformatf("dir%0d_illegal", i), bus.illegal, d_ill[i]);
    end
    bus.in_valid = 0;
    repeat (2) cyc();
    bus.out_ready = 0;
    bus.in_valid = 1;
    bus.instr = 32'h84006011;
    chk("fill0_in_ready", bus.in_ready, 1);
    cyc();
    bus.instr = 32'h8400400A;
    bus.rs2_val = 32'hCAFEF00D;
    chk("fill1_in_ready", bus.in_ready, 1);
    cyc();
    bus.instr = 32'h03000ABC;
    chk("full_refuse", bus.in_ready, 0);
    cyc();
    bus.out_ready = 1;
    chk("pop_no_push", bus.in_ready, 0);
    cyc();
    chk("ready_after_pop", bus.in_ready, 1);
    cyc();
    bus.in_valid = 0;
    repeat (3) cyc();
    chk_idle("drained");
    bus.out_ready = 0;
    bus.in_valid = 1;
    bus.instr = 32'h10800004;
    cyc();
    bus.instr = 32'hC4006123;
    cyc();
    bus.flush = 1;
    bus.instr = 32'h03000001;
    cyc();
    bus.flush = 0;
    bus.in_valid = 0;
    chk_idle("flush");
    chk("flush_in_ready", bus.in_ready, 1);
    cyc();
    chk("flush_drop_push", bus.out_valid, 0);
    bus.in_valid = 1;
    bus.instr = 32'h8400600F;
    cyc();
    bus.instr = 32'h84004001;
    bus.rs2_val = 32'h55AA55AA;
    cyc();
    bus.in_valid = 0;
    cyc();
    chk("stall_valid", bus.out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_in_ready", bus.in_ready, 0);
    cyc();
    rst_n = 1;
    cyc();
    chk("rerst_in_ready", bus.in_ready, 1);
    chk("rerst_out_valid", bus.out_valid, 0);
    for (int i = 0; i < 60; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.flush = $urandom_range(0, 15) == 0;
      bus.instr = $urandom;
      bus.rs2_val = $urandom;
      cyc();
    end
    bus.flush = 0;
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (4) cyc();
    chk("drain_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
